// File: rtl/rv32i_mc_ctrl.sv
// ============================================================================
// Module      : rv32i_mc_ctrl
// Description : Multicycle Moore-FSM control unit for the RV32I core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_mc_ctrl #(
    parameter int MEM_HANDSHAKE   = 1,
    parameter int CNT_W           = 32,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [2:0]       imm_src,
    output logic [1:0]       result_src,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR_ADR = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    state_t           r_state;
    state_t           w_dec_nx;
    state_t           w_illegal_nx;
    logic [CNT_W-1:0] r_retired;
    logic             w_ready;
    logic             w_retire;
    logic             w_alu_f3_ok;
    logic             w_r_ok;
    logic             w_br_ok;
    logic             w_taken;
    logic [2:0]       w_alu_ctl;
    logic             w_unused;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_op = instr[6:0];
    assign w_f3 = instr[14:12];
    assign w_f7 = instr[31:25];

    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused = ^{instr[24:15], instr[11:7]};

    assign w_ready      = (MEM_HANDSHAKE == 0) || mem_ready;
    assign w_illegal_nx = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;

    assign w_alu_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b010) || (w_f3 == 3'b100) ||
                         (w_f3 == 3'b110) || (w_f3 == 3'b111);
    assign w_r_ok      = w_alu_f3_ok &&
                         ((w_f7 == 7'h00) || ((w_f7 == 7'h20) && (w_f3 == 3'b000)));
    assign w_br_ok     = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                         (w_f3 == 3'b100) || (w_f3 == 3'b101);

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                      (r_state == S_BRANCH) || ((r_state == S_MEMWRITE) && w_ready);

    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = !lt;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_ctl = 3'b000;
        case (w_f3)
            3'b000:  w_alu_ctl = ((r_state == S_EXEC_R) && w_f7[5]) ? 3'b001 : 3'b000;
            3'b100:  w_alu_ctl = 3'b100;
            3'b110:  w_alu_ctl = 3'b011;
            3'b111:  w_alu_ctl = 3'b010;
            3'b010:  w_alu_ctl = 3'b101;
            default: w_alu_ctl = 3'b000;
        endcase
    end

    always_comb begin
        w_dec_nx = w_illegal_nx;
        case (w_op)
            7'b0000011, 7'b0100011: w_dec_nx = S_MEMADR;
            7'b0110011: w_dec_nx = w_r_ok      ? S_EXEC_R : w_illegal_nx;
            7'b0010011: w_dec_nx = w_alu_f3_ok ? S_EXEC_I : w_illegal_nx;
            7'b1100011: w_dec_nx = w_br_ok     ? S_BRANCH : w_illegal_nx;
            7'b1101111: w_dec_nx = S_JAL;
            7'b1100111: w_dec_nx = S_JALR_ADR;
            7'b0110111: w_dec_nx = S_LUI;
            default:    w_dec_nx = w_illegal_nx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH:    if (w_ready) r_state <= S_DECODE;
                S_DECODE:   r_state <= w_dec_nx;
                S_MEMADR:   r_state <= instr[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
                S_MEMWB, S_ALUWB, S_BRANCH: r_state <= S_FETCH;
                S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: r_state <= S_ALUWB;
                S_JALR_ADR: r_state <= S_JAL;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
            if (w_retire) r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign retired = rst_n ? r_retired : '0;

    // Moore decode; only FETCH handshake strobes and branch pc_write see inputs.
    always_comb begin
        mem_req     = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        imm_src     = 3'b000;
        result_src  = 2'b00;
        halt        = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = w_ready;
                    pc_write   = w_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = 3'b010;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = instr[5] ? 3'b001 : 3'b000;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a   = 2'b10;
                    alu_control = w_alu_ctl;
                end
                S_EXEC_I: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = w_alu_ctl;
                end
                S_ALUWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = 3'b001;
                    pc_write    = w_taken;
                end
                S_JALR_ADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    imm_src   = 3'b100;
                end
                S_TRAP:  halt = 1'b1;
                default: halt = 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multicycle control unit for the next-generation RV32I core. It replaces the single-cycle combinational control unit with a Moore FSM, so the datapath shares one ALU and one unified memory across cycles. It adds memory request/ready handshaking, bne/blt/bge, jalr and lui, illegal-instruction trapping and a retired-instruction counter. It sits beside the multicycle datapath in the processor top, taking instr/zero/lt and driving every datapath select and enable.

Parameters:
MEM_HANDSHAKE, 1, 1 = wait states hold on mem_ready; 0 = mem_ready ignored and treated as 1
CNT_W, 32, width of the retired-instruction counter
TRAP_ON_ILLEGAL, 1, 1 = unknown opcode/funct enters TRAP; 0 = treated as NOP and returns to FETCH

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
instr  in  32  instruction register contents (op=[6:0], f3=[14:12], f7=[31:25])
zero  in  1  ALU result == 0
lt  in  1  ALU signed-less-than flag from the sub comparison
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access requested
adr_src  out  1  0 = PC, 1 = Result
mem_write  out  1  store strobe, valid with mem_req
ir_write  out  1  latch instr/OldPC
pc_write  out  1  PC <= Result
reg_write  out  1  register file write
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
alu_src_b  out  2  00 rs2, 01 ImmExt, 10 const 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
halt  out  1  core in TRAP
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: while rst_n=0 at a rising edge, state<=FETCH and retired<=0. While rst_n=0, all outputs are forced to 0. Reset mid-instruction aborts it without counting it.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JALR_ADR, JAL, LUI, TRAP.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. When ready: ir_write=1 and pc_write=1 for that cycle only, then go to DECODE. Otherwise stay in FETCH with ir_write=0 and pc_write=0.
- DECODE: alu_src_a=01, alu_src_b=01, add, imm_src=B (computes PC+imm into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - 0110111 -> LUI
  - anything else -> TRAP (or FETCH if TRAP_ON_ILLEGAL=0)
- MEMADR: rs1+imm; imm_src=I for lw, S for sw. Next state MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Hold until ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until ready, then go to FETCH. mem_write stays high for every waiting cycle.
- EXEC_R/EXEC_I: alu_src_a=10, alu_src_b=00 (R) or 01 (I), then go to ALUWB. alu_control decode:
  - f3 000 -> sub only when R and f7[5]=1, else add
  - f3 100 -> xor
  - f3 110 -> or
  - f3 111 -> and
  - f3 010 -> slt
  - any other f3/f7 combination is illegal
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00. pc_write = taken, where beq: zero, bne: !zero, blt: lt, bge: !lt; other f3 is illegal. Then go to FETCH.
- JALR_ADR: rs1+imm(I) into ALUOut, then go to JAL.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 (PC<=ALUOut), then go to ALUWB (rd<=OldPC+4).
- LUI: alu_src_a=11, alu_src_b=01, imm_src=U, add, then go to ALUWB.
- TRAP: halt=1, every other output is 0. Only reset leaves TRAP.
- Latency with zero-wait memory:
  - lw: 5 cycles
  - sw, R, I, jal, lui: 4 cycles
  - beq family: 3 cycles
  - jalr: 5 cycles
  - Each memory wait cycle adds 1.
- retired increments on the transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^CNT_W. Trapped instructions are not counted.
- Unused outputs in any state are 0. Outputs depend only on state and instr, never on mem_ready, except ir_write and pc_write in FETCH.

Test Plan:
- Reset held 3 cycles then released, mem_ready=1, instr=add x3,x1,x2 (0x002081B3) -> states FETCH, DECODE, EXEC_R, ALUWB, FETCH; reg_write=1 only in ALUWB; retired=1.
- lw x5,4(x1) (0x0040A283) with mem_ready low 2 cycles in FETCH and 1 in MEMREAD -> 8 cycles total; ir_write pulses once; result_src=01 in MEMWB.
- beq with zero=1 then bne with zero=1 -> pc_write=1 in BRANCH for beq, 0 for bne; each 3 cycles; retired +2.
- jalr x1,0(x2) (0x000100E7) -> DECODE, JALR_ADR, JAL(pc_write=1), ALUWB(reg_write=1); lui x7,0x12345 (0x123453B7) -> alu_src_a=11, imm_src=100.
- instr=0xFFFFFFFF -> TRAP after DECODE; halt=1 and all controls 0 for 10 cycles; retired unchanged. Reset mid-MEMWRITE -> mem_write=0 the next cycle and state FETCH.
- CNT_W=4, 17 back-to-back addi instructions -> retired wraps to 1.
